// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered, glitch-free clk_out of period N,
// ratio updates applied only at period wrap. Optional tick strobe under CLK_DIV_TICK_EN.
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             clk_out,
  output logic             ratio_ack
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_R = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             ratio_ack_q, ratio_ack_d;
  logic [CNT_W-1:0] hi, last, ld_val;
  logic             wrap;
`ifdef CLK_DIV_TICK_EN
  logic             tick_q, tick_d;
`endif

  always_comb begin
    // ceil(N/2) high cycles; fits CNT_W since cur_div never exceeds 2^CNT_W-1
    hi          = cur_div_q - (cur_div_q >> 1);
    last        = cur_div_q - CNT_W'(1);
    wrap        = en && (cnt_q == last);
    ld_val      = (div_ratio < MIN_R) ? MIN_R : div_ratio;

    cnt_d       = cnt_q;
    clk_out_d   = clk_out_q;
    cur_div_d   = cur_div_q;
    pend_div_d  = pend_div_q;
    pend_vld_d  = pend_vld_q;
    ratio_ack_d = 1'b0;

    if (en) begin
      cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
      clk_out_d = (cnt_q < hi);
    end

    if (wrap && pend_vld_q) begin
      cur_div_d   = pend_div_q;
      pend_vld_d  = 1'b0;
      ratio_ack_d = 1'b1;
    end

    // A load coinciding with a wrap becomes pending for the following wrap
    if (load) begin
      pend_div_d = ld_val;
      pend_vld_d = 1'b1;
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_comb tick_d = en && (cnt_q == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      cur_div_q   <= DEF_R;
      pend_div_q  <= DEF_R;
      pend_vld_q  <= 1'b0;
      clk_out_q   <= 1'b0;
      ratio_ack_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      pend_vld_q  <= pend_vld_d;
      clk_out_q   <= clk_out_d;
      ratio_ack_q <= ratio_ack_d;
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_d;
  end
  assign tick = tick_q;
`endif

  assign clk_out   = clk_out_q;
  assign ratio_ack = ratio_ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a behavioural model pushes expected outputs per
// driven cycle; each test pops and compares, plus direct period/duty checks.
module tb_clk_div_prog;

  typedef struct packed {
    logic co;
    logic ack;
    logic tk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic       clk_out, ratio_ack, tick_obs;

`ifdef CLK_DIV_TICK_EN
  localparam bit HAS_TICK = 1'b1;
  logic tick;
  assign tick_obs = tick;
  clk_div_prog #(.CNT_W(8), .DEF_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_ratio(div_ratio),
    .clk_out(clk_out), .ratio_ack(ratio_ack), .tick(tick));
`else
  localparam bit HAS_TICK = 1'b0;
  assign tick_obs = 1'b0;
  clk_div_prog #(.CNT_W(8), .DEF_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_ratio(div_ratio),
    .clk_out(clk_out), .ratio_ack(ratio_ack));
`endif

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  int m_cnt, m_cur, m_pend;
  bit m_pv, m_co;

  task automatic model_reset();
    m_cnt = 0; m_cur = 2; m_pend = 2; m_pv = 0; m_co = 0;
    sb.delete();
  endtask

  function automatic exp_t model(bit e_i, bit l_i, int r_i);
    exp_t x;
    x = '0;
    if (e_i) begin
      x.co = (m_cnt < (m_cur + 1) / 2);
      x.tk = HAS_TICK && (m_cnt == 0);
      if (m_cnt == m_cur - 1) begin
        if (m_pv) begin m_cur = m_pend; m_pv = 0; x.ack = 1'b1; end
        m_cnt = 0;
      end else m_cnt++;
    end else x.co = m_co;
    if (l_i) begin m_pend = (r_i < 2) ? 2 : r_i; m_pv = 1; end
    m_co = x.co;
    return x;
  endfunction

  task automatic step(input bit e_i, input bit l_i, input int r_i);
    en = e_i; load = l_i; div_ratio = 8'(r_i);
    sb.push_back(model(e_i, l_i, r_i));
    @(posedge clk); #1;
    e = sb.pop_front();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    #12;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset clk_out: got %b want 0", clk_out); end
    checks++; if (ratio_ack !== 1'b0) begin errors++; $display("FAIL reset ratio_ack: got %b want 0", ratio_ack); end
    checks++; if (tick_obs !== 1'b0) begin errors++; $display("FAIL reset tick: got %b want 0", tick_obs); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_default();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL default sb[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      checks++; if (clk_out !== logic'(i % 2 == 0) || ratio_ack !== 1'b0) begin errors++; $display("FAIL default toggle[%0d]: got co=%b ack=%b want co=%b ack=0", i, clk_out, ratio_ack, i % 2 == 0); end
    end
  endtask

  task automatic test_load5();
    int acks = 0;
    bit seen = 0;
    logic hist[$];
    step(1, 1, 5);
    checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL load5 sb load: got %b want %b", {clk_out, ratio_ack, tick_obs}, e); end
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL load5 sb[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      if (seen) hist.push_back(clk_out);
      if (ratio_ack) begin acks++; seen = 1; end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL load5 ack count: got %0d want 1", acks); end
    checks++;
    if (hist.size() < 10) begin errors++; $display("FAIL load5 history: got %0d samples want 10", hist.size()); end
    else for (int k = 0; k < 10; k++) begin
      if (hist[k] !== logic'(k % 5 < 3)) begin errors++; $display("FAIL load5 pattern[%0d]: got %b want %b", k, hist[k], k % 5 < 3); break; end
    end
  endtask

  task automatic test_clamp();
    int vals[2] = '{0, 1};
    bit got;
    foreach (vals[v]) begin
      step(1, 1, vals[v]);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL clamp%0d sb load: got %b want %b", vals[v], {clk_out, ratio_ack, tick_obs}, e); end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        step(1, 0, 0);
        checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL clamp%0d sb wait[%0d]: got %b want %b", vals[v], i, {clk_out, ratio_ack, tick_obs}, e); end
        got = ratio_ack;
      end
      checks++; if (!got) begin errors++; $display("FAIL clamp%0d ack timeout: got none want 1 pulse", vals[v]); end
      for (int k = 0; k < 6; k++) begin
        step(1, 0, 0);
        checks++; if (clk_out !== logic'(k % 2 == 0) || ratio_ack !== 1'b0) begin errors++; $display("FAIL clamp%0d period2[%0d]: got co=%b ack=%b want co=%b ack=0", vals[v], k, clk_out, ratio_ack, k % 2 == 0); end
      end
    end
  endtask

  task automatic test_en_hold();
    bit got = 0;
    int highs = 0, lows = 0, acks = 0;
    step(1, 1, 7);
    for (int i = 0; i < 10 && !got; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL hold sb wait[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      got = ratio_ack;
    end
    checks++; if (!got) begin errors++; $display("FAIL hold ack7 timeout: got none want 1 pulse"); end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      if (clk_out) highs++;
    end
    // freeze mid-high; a load taken now must wait for the next wrap
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 1), 3);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e || clk_out !== 1'b1) begin errors++; $display("FAIL hold frozen[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
    end
    for (int i = 0; i < 10 && clk_out; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL hold sb high[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      if (clk_out) highs++; else lows++;
      if (ratio_ack) acks++;
    end
    for (int i = 0; i < 10 && !clk_out; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL hold sb low[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      if (!clk_out) lows++;
      if (ratio_ack) acks++;
    end
    checks++; if (highs != 4) begin errors++; $display("FAIL hold high total: got %0d want 4", highs); end
    checks++; if (lows != 3) begin errors++; $display("FAIL hold low total: got %0d want 3", lows); end
    checks++; if (acks != 1) begin errors++; $display("FAIL hold ack3 count: got %0d want 1", acks); end
  endtask

  task automatic test_last_wins();
    int acks = 0;
    bit seen = 0;
    logic hist[$];
    for (int i = 0; i < 10 && m_cnt != 0; i++) step(1, 0, 0);
    step(1, 1, 6);
    step(1, 1, 4);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL lastwins sb[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      if (seen) hist.push_back(clk_out);
      if (ratio_ack) begin acks++; seen = 1; end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL lastwins ack count: got %0d want 1", acks); end
    checks++;
    if (hist.size() < 8) begin errors++; $display("FAIL lastwins history: got %0d samples want 8", hist.size()); end
    else for (int k = 0; k < 8; k++) begin
      if (hist[k] !== logic'(k % 4 < 2)) begin errors++; $display("FAIL lastwins pattern[%0d]: got %b want %b", k, hist[k], k % 4 < 2); break; end
    end
  endtask

  task automatic test_n255();
    bit got = 0;
    int highs = 0, lows = 0, ticks = 0;
    step(1, 1, 255);
    for (int i = 0; i < 10 && !got; i++) begin
      step(1, 0, 0);
      got = ratio_ack;
    end
    checks++; if (!got) begin errors++; $display("FAIL n255 ack timeout: got none want 1 pulse"); end
    for (int k = 0; k < 256; k++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL n255 sb[%0d]: got %b want %b", k, {clk_out, ratio_ack, tick_obs}, e); end
      if (k < 255) begin
        if (clk_out) highs++; else lows++;
        if (tick_obs) ticks++;
      end else begin
        checks++; if (clk_out !== 1'b1 || tick_obs !== HAS_TICK) begin errors++; $display("FAIL n255 next rise: got co=%b tick=%b want 1 %b", clk_out, tick_obs, HAS_TICK); end
      end
      if (k == 0) begin
        checks++; if (tick_obs !== HAS_TICK) begin errors++; $display("FAIL n255 tick align: got %b want %b", tick_obs, HAS_TICK); end
      end
    end
    checks++; if (highs != 128) begin errors++; $display("FAIL n255 high: got %0d want 128", highs); end
    checks++; if (lows != 127) begin errors++; $display("FAIL n255 low: got %0d want 127", lows); end
    checks++; if (ticks != (HAS_TICK ? 1 : 0)) begin errors++; $display("FAIL n255 ticks: got %0d want %0d", ticks, HAS_TICK ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 9);
    step(1, 0, 0);
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL rstmid precond: got co=%b want 1", clk_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rstmid async clk_out: got %b want 0", clk_out); end
    checks++; if (ratio_ack !== 1'b0 || tick_obs !== 1'b0) begin errors++; $display("FAIL rstmid ack/tick: got %b%b want 00", ratio_ack, tick_obs); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      checks++; if ({clk_out, ratio_ack, tick_obs} !== e) begin errors++; $display("FAIL rstmid sb[%0d]: got %b want %b", i, {clk_out, ratio_ack, tick_obs}, e); end
      checks++; if (clk_out !== logic'(i % 2 == 0) || ratio_ack !== 1'b0) begin errors++; $display("FAIL rstmid period2[%0d]: got co=%b ack=%b want co=%b ack=0", i, clk_out, ratio_ack, i % 2 == 0); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_load5();
    test_clamp();
    test_en_hold();
    test_last_wins();
    test_n255();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
